// File: rtl/nfu_pkg.sv
// Shared types and default latencies for the NFU sequencing controller.
package nfu_pkg;

    localparam int BIT_WIDTH = 16;
    localparam int Tn        = 16;

    localparam int NUM_SEG_DEF  = 16;
    localparam int MEM_LAT_DEF  = 1;
    localparam int ACC_LAT_DEF  = 3;
    localparam int NFU3_LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COEF,
        ISSUE,
        DRAIN,
        DONE
    } nfu_state_e;

endpackage

// File: rtl/nfu_tile_cnt.sv
// Loadable up-counter with a terminal-count flag against a runtime limit.
module nfu_tile_cnt
    import nfu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/nfu_ctrl.sv
// Sequencer for the NFU multiply/accumulate/sigmoid pipeline: walks a layer as
// output tiles x input tiles, one output tile in flight at a time.
module nfu_ctrl
    import nfu_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int CNT_W    = 8,
    parameter int NUM_SEG  = NUM_SEG_DEF,
    parameter int MEM_LAT  = MEM_LAT_DEF,
    parameter int ACC_LAT  = ACC_LAT_DEF,
    parameter int NFU3_LAT = NFU3_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic [CNT_W-1:0]           i_num_in_tiles,
    input  logic [CNT_W-1:0]           i_num_out_tiles,
    input  logic                       i_psum_in,
    input  logic                       i_psum_out,
    input  logic                       i_load_coef,
    output logic [$clog2(NUM_SEG)-1:0] o_coef_addr,
    output logic                       o_load_sigmoid_coef,
    output logic                       o_nbin_rd_en,
    output logic [ADDR_W-1:0]          o_nbin_addr,
    output logic                       o_sb_rd_en,
    output logic [ADDR_W-1:0]          o_sb_addr,
    output logic                       o_nbout_rd_en,
    output logic [ADDR_W-1:0]          o_nbout_rd_addr,
    output logic                       o_load_nbout,
    output logic                       o_psum_zero,
    output logic                       o_nbout_nfu2_nfu3,
    output logic                       o_nbout_wr_en,
    output logic [ADDR_W-1:0]          o_nbout_wr_addr,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int SEG_W = $clog2(NUM_SEG);
    localparam int LAT_W = $clog2(ACC_LAT + NFU3_LAT + NUM_SEG + (1 << CNT_W));

    // Tile-relative cycle offsets of the accumulator seed and its NBout prefetch.
    localparam logic [LAT_W-1:0] SEED_T = LAT_W'(ACC_LAT - 1);
    localparam logic [LAT_W-1:0] PREF_T = LAT_W'(ACC_LAT - 1 - MEM_LAT);
    localparam logic [LAT_W-1:0] COEF_T = LAT_W'(NUM_SEG - 1);

    nfu_state_e state, state_nxt;

    logic [CNT_W-1:0]  n_in, n_out;
    logic              psum_in, psum_out;
    logic [ADDR_W-1:0] sb_cnt;

    logic [CNT_W-1:0]  in_cnt, out_cnt;
    logic              in_tc, out_tc;
    logic [LAT_W-1:0]  lat_cnt, lat_term, wr_rel;
    logic              lat_tc;

    logic in_load, in_en, out_load, out_en, lat_load;
    logic tile_act, wr_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_in     <= '0;
            n_out    <= '0;
            psum_in  <= 1'b0;
            psum_out <= 1'b0;
        end else if (state == IDLE && i_start) begin
            n_in     <= (i_num_in_tiles == '0)  ? CNT_W'(1) : i_num_in_tiles;
            n_out    <= (i_num_out_tiles == '0) ? CNT_W'(1) : i_num_out_tiles;
            psum_in  <= i_psum_in;
            psum_out <= i_psum_out;
        end
    end

    // Write lands after the last product clears NFU-2, plus NFU-3 when it is selected.
    always_comb begin
        wr_rel = SEED_T + LAT_W'(n_in) + (psum_out ? '0 : LAT_W'(NFU3_LAT));
    end

    assign tile_act = (state == ISSUE) || (state == DRAIN);
    assign wr_fire  = (state == DRAIN) && lat_tc;
    assign lat_term = (state == LOAD_COEF) ? COEF_T : wr_rel;
    assign lat_load = (state == IDLE) || (state == LOAD_COEF && lat_tc) || wr_fire;
    assign in_load  = (state == IDLE) || (state == ISSUE && in_tc);
    assign in_en    = (state == ISSUE);
    assign out_load = (state == IDLE);
    assign out_en   = wr_fire;

    nfu_tile_cnt #(.W(CNT_W)) u_in_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (in_load),
        .en       (in_en),
        .load_val ('0),
        .term     (n_in - 1'b1),
        .cnt      (in_cnt),
        .tc       (in_tc)
    );

    nfu_tile_cnt #(.W(CNT_W)) u_out_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (out_load),
        .en       (out_en),
        .load_val ('0),
        .term     (n_out - 1'b1),
        .cnt      (out_cnt),
        .tc       (out_tc)
    );

    // Doubles as the coefficient index during LOAD_COEF and the tile clock afterwards.
    nfu_tile_cnt #(.W(LAT_W)) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lat_load),
        .en       (1'b1),
        .load_val ('0),
        .term     (lat_term),
        .cnt      (lat_cnt),
        .tc       (lat_tc)
    );

    // SB address runs linearly across all output tiles of the layer.
    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            sb_cnt <= '0;
        end else if (state == ISSUE) begin
            sb_cnt <= sb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (i_start) state_nxt = i_load_coef ? LOAD_COEF : ISSUE;
            LOAD_COEF: if (lat_tc) state_nxt = ISSUE;
            ISSUE:     if (in_tc) state_nxt = DRAIN;
            DRAIN:     if (lat_tc) state_nxt = out_tc ? DONE : ISSUE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_load_sigmoid_coef = (state == LOAD_COEF);
        o_coef_addr         = (state == LOAD_COEF) ? lat_cnt[SEG_W-1:0] : '0;
        o_nbin_rd_en        = (state == ISSUE);
        o_sb_rd_en          = (state == ISSUE);
        o_nbin_addr         = (state == ISSUE) ? ADDR_W'(in_cnt) : '0;
        o_sb_addr           = (state == ISSUE) ? sb_cnt : '0;
        o_nbout_rd_en       = tile_act && psum_in && (lat_cnt == PREF_T);
        o_nbout_rd_addr     = o_nbout_rd_en ? ADDR_W'(out_cnt) : '0;
        o_load_nbout        = tile_act && (lat_cnt == SEED_T);
        o_psum_zero         = o_load_nbout && !psum_in;
        o_nbout_wr_en       = wr_fire;
        o_nbout_wr_addr     = wr_fire ? ADDR_W'(out_cnt) : '0;
        o_busy              = (state != IDLE);
        o_nbout_nfu2_nfu3   = o_busy && psum_out;
        o_done              = (state == DONE);
    end

endmodule

// File: tb/tb_nfu_ctrl.sv
// Scoreboard bench for nfu_ctrl: stimulus pushes expected events per output
// channel, a negedge monitor pops and compares whatever the controller presents.
module tb_nfu_ctrl;

    localparam int ADDR_W   = 10;
    localparam int CNT_W    = 8;
    localparam int NUM_SEG  = 16;
    localparam int MEM_LAT  = 1;
    localparam int ACC_LAT  = 3;
    localparam int NFU3_LAT = 2;
    localparam int NO_LIM   = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start;
    logic [CNT_W-1:0]  i_num_in_tiles, i_num_out_tiles;
    logic              i_psum_in, i_psum_out, i_load_coef;
    logic [3:0]        o_coef_addr;
    logic              o_load_sigmoid_coef;
    logic              o_nbin_rd_en, o_sb_rd_en, o_nbout_rd_en, o_nbout_wr_en;
    logic [ADDR_W-1:0] o_nbin_addr, o_sb_addr, o_nbout_rd_addr, o_nbout_wr_addr;
    logic              o_load_nbout, o_psum_zero, o_nbout_nfu2_nfu3, o_busy, o_done;

    always #5 clk = ~clk;

    nfu_ctrl #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_SEG(NUM_SEG),
        .MEM_LAT(MEM_LAT), .ACC_LAT(ACC_LAT), .NFU3_LAT(NFU3_LAT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_start             (i_start),
        .i_num_in_tiles      (i_num_in_tiles),
        .i_num_out_tiles     (i_num_out_tiles),
        .i_psum_in           (i_psum_in),
        .i_psum_out          (i_psum_out),
        .i_load_coef         (i_load_coef),
        .o_coef_addr         (o_coef_addr),
        .o_load_sigmoid_coef (o_load_sigmoid_coef),
        .o_nbin_rd_en        (o_nbin_rd_en),
        .o_nbin_addr         (o_nbin_addr),
        .o_sb_rd_en          (o_sb_rd_en),
        .o_sb_addr           (o_sb_addr),
        .o_nbout_rd_en       (o_nbout_rd_en),
        .o_nbout_rd_addr     (o_nbout_rd_addr),
        .o_load_nbout        (o_load_nbout),
        .o_psum_zero         (o_psum_zero),
        .o_nbout_nfu2_nfu3   (o_nbout_nfu2_nfu3),
        .o_nbout_wr_en       (o_nbout_wr_en),
        .o_nbout_wr_addr     (o_nbout_wr_addr),
        .o_busy              (o_busy),
        .o_done              (o_done)
    );

    typedef struct {
        int cyc;
        int a;
        int b;
        int e;
    } ev_t;

    ev_t q_coef[$], q_rd[$], q_nbrd[$], q_seed[$], q_wr[$], q_done[$];

    int   cyc = 0;
    logic rst_q = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    function automatic ev_t mk(input int c, input int a, input int b, input int e);
        ev_t r;
        r.cyc = c; r.a = a; r.b = b; r.e = e;
        return r;
    endfunction

    task automatic cmp(input string name, input ev_t got, input ev_t exp);
        checks++;
        if (got.cyc != exp.cyc || got.a != exp.a || got.b != exp.b || got.e != exp.e) begin
            errors++;
            $display("FAIL %s: got cyc=%0d a=%0d b=%0d e=%0d, expected cyc=%0d a=%0d b=%0d e=%0d",
                     name, got.cyc, got.a, got.b, got.e, exp.cyc, exp.a, exp.b, exp.e);
        end
    endtask

    task automatic unexpected(input string name, input ev_t got);
        checks++;
        errors++;
        $display("FAIL %s: got cyc=%0d a=%0d b=%0d e=%0d, expected no event",
                 name, got.cyc, got.a, got.b, got.e);
    endtask

    task automatic missed(input string name, input ev_t exp);
        checks++;
        errors++;
        $display("FAIL %s: got no event, expected cyc=%0d a=%0d b=%0d e=%0d",
                 name, exp.cyc, exp.a, exp.b, exp.e);
    endtask

    // Expected event stream of one layer; events at or after lim are not pushed.
    task automatic push_layer(input int s, input int n_in, input int n_out, input bit pin,
                              input bit pout, input bit coef, input int lim);
        int nn, no, c0, c, d, sb;
        nn = (n_in == 0) ? 1 : n_in;
        no = (n_out == 0) ? 1 : n_out;
        c0 = s + 1;
        if (coef) begin
            for (int i = 0; i < NUM_SEG; i++)
                if (s + 1 + i < lim) q_coef.push_back(mk(s + 1 + i, i, 0, 1));
            c0 = c0 + NUM_SEG;
        end
        d  = ACC_LAT + nn - 1 + (pout ? 0 : NFU3_LAT) + 1;
        sb = 0;
        for (int o = 0; o < no; o++) begin
            c = c0 + o * d;
            for (int k = 0; k < nn; k++) begin
                if (c + k < lim) q_rd.push_back(mk(c + k, k, sb, 3));
                sb++;
            end
            if (pin && c + ACC_LAT - 1 - MEM_LAT < lim)
                q_nbrd.push_back(mk(c + ACC_LAT - 1 - MEM_LAT, o, 0, 1));
            if (c + ACC_LAT - 1 < lim) q_seed.push_back(mk(c + ACC_LAT - 1, pin ? 0 : 1, 0, 1));
            if (c + d - 1 < lim) q_wr.push_back(mk(c + d - 1, o, pout ? 1 : 0, 1));
        end
        if (c0 + no * d < lim) q_done.push_back(mk(c0 + no * d, 0, 0, 1));
    endtask

    always @(negedge clk) begin
        ev_t g;
        if (!rst_q) begin
            checks++;
            if ({o_coef_addr, o_load_sigmoid_coef, o_nbin_rd_en, o_nbin_addr, o_sb_rd_en, o_sb_addr,
                 o_nbout_rd_en, o_nbout_rd_addr, o_load_nbout, o_psum_zero, o_nbout_nfu2_nfu3,
                 o_nbout_wr_en, o_nbout_wr_addr, o_busy, o_done} != '0) begin
                errors++;
                $display("FAIL reset_outputs: cyc=%0d busy=%0b wr_en=%0b rd_en=%0b done=%0b, expected all zero",
                         cyc, o_busy, o_nbout_wr_en, o_nbin_rd_en, o_done);
            end
        end
        if (o_load_sigmoid_coef) begin
            g = mk(cyc, int'(o_coef_addr), 0, 1);
            if (q_coef.size() == 0) unexpected("coef", g); else cmp("coef", g, q_coef.pop_front());
        end
        if (o_nbin_rd_en || o_sb_rd_en) begin
            g = mk(cyc, int'(o_nbin_addr), int'(o_sb_addr), int'({o_nbin_rd_en, o_sb_rd_en}));
            if (q_rd.size() == 0) unexpected("rd", g); else cmp("rd", g, q_rd.pop_front());
        end
        if (o_nbout_rd_en) begin
            g = mk(cyc, int'(o_nbout_rd_addr), 0, 1);
            if (q_nbrd.size() == 0) unexpected("nbout_rd", g); else cmp("nbout_rd", g, q_nbrd.pop_front());
        end
        if (o_load_nbout || o_psum_zero) begin
            g = mk(cyc, int'(o_psum_zero), 0, int'(o_load_nbout));
            if (q_seed.size() == 0) unexpected("seed", g); else cmp("seed", g, q_seed.pop_front());
        end
        if (o_nbout_wr_en) begin
            g = mk(cyc, int'(o_nbout_wr_addr), int'(o_nbout_nfu2_nfu3), 1);
            if (q_wr.size() == 0) unexpected("wr", g); else cmp("wr", g, q_wr.pop_front());
        end
        if (o_done) begin
            g = mk(cyc, 0, 0, 1);
            if (q_done.size() == 0) unexpected("done", g); else cmp("done", g, q_done.pop_front());
        end
        // Anything still queued for an earlier cycle never showed up.
        while (q_coef.size() > 0 && q_coef[0].cyc < cyc) missed("coef", q_coef.pop_front());
        while (q_rd.size() > 0 && q_rd[0].cyc < cyc) missed("rd", q_rd.pop_front());
        while (q_nbrd.size() > 0 && q_nbrd[0].cyc < cyc) missed("nbout_rd", q_nbrd.pop_front());
        while (q_seed.size() > 0 && q_seed[0].cyc < cyc) missed("seed", q_seed.pop_front());
        while (q_wr.size() > 0 && q_wr[0].cyc < cyc) missed("wr", q_wr.pop_front());
        while (q_done.size() > 0 && q_done[0].cyc < cyc) missed("done", q_done.pop_front());
    end

    task automatic start_layer(input int n_in, input int n_out, input bit pin, input bit pout,
                               input bit coef, input int lim, output int s);
        @(negedge clk);
        s = cyc;
        push_layer(s, n_in, n_out, pin, pout, coef, lim);
        i_num_in_tiles  = CNT_W'(n_in);
        i_num_out_tiles = CNT_W'(n_out);
        i_psum_in       = pin;
        i_psum_out      = pout;
        i_load_coef     = coef;
        i_start         = 1'b1;
        @(negedge clk);
        i_start         = 1'b0;
        i_num_in_tiles  = 8'hA5;
        i_num_out_tiles = 8'h5A;
        i_psum_in       = ~pin;
        i_psum_out      = ~pout;
        i_load_coef     = ~coef;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!o_busy) break;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int s;
        rst_n           = 1'b0;
        i_start         = 1'b0;
        i_num_in_tiles  = '0;
        i_num_out_tiles = '0;
        i_psum_in       = 1'b0;
        i_psum_out      = 1'b0;
        i_load_coef     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4x2 layer abandoned by a one-cycle reset three cycles into ISSUE.
        start_layer(4, 2, 1'b0, 1'b0, 1'b0, 0, s);
        push_layer(s, 4, 2, 1'b0, 1'b0, 1'b0, s + 4);
        while (cyc < s + 3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        // Coefficient load ahead of a 2x1 layer.
        start_layer(2, 1, 1'b0, 1'b0, 1'b1, NO_LIM, s);
        wait_idle();

        // 4x2, zero seed, sigmoid results.
        start_layer(4, 2, 1'b0, 1'b0, 1'b0, NO_LIM, s);
        wait_idle();

        // 3x1, seed from NBout, partial sums written back.
        start_layer(3, 1, 1'b1, 1'b1, 1'b0, NO_LIM, s);
        wait_idle();

        // Zero tile counts act as 1x1.
        start_layer(0, 0, 1'b0, 1'b0, 1'b0, NO_LIM, s);
        wait_idle();

        // 2x2 with stray starts during ISSUE, DRAIN and the DONE cycle.
        start_layer(2, 2, 1'b1, 1'b0, 1'b0, NO_LIM, s);
        for (int p = 0; p < 3; p++) begin
            while (cyc < s + ((p == 0) ? 2 : (p == 1) ? 6 : 15)) @(negedge clk);
            i_num_in_tiles  = 8'd5;
            i_num_out_tiles = 8'd3;
            i_load_coef     = 1'b1;
            i_psum_out      = 1'b1;
            i_start         = 1'b1;
            @(negedge clk);
            i_start         = 1'b0;
        end
        wait_idle();
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nfu_ctrl.md
Name: nfu_ctrl

Overview:
- Sequencing controller for the three-stage NFU pipeline (NFU-1 multiply, NFU-2 accumulate, NFU-3 sigmoid).
- Walks a layer as output tiles × input tiles. Drives NBin/SB/NBout addressing and the pipeline controls (load_nbout, partial-sum zeroing, nfu2/nfu3 output select, sigmoid coefficient load).
- Runs one output tile in flight at a time. Sits between the layer scheduler (start/config) and top_pipeline plus its buffers.

Parameters:
- ADDR_W, 10, NBin/SB/NBout address width.
- CNT_W, 8, width of tile-count config fields.
- NUM_SEG, 16, sigmoid piecewise segments to load.
- MEM_LAT, 1, buffer read-issue to data-at-pipeline-input latency in cycles.
- ACC_LAT, 3, read-issue to product entering the NFU-2 accumulator. Constraint: ACC_LAT > MEM_LAT.
- NFU3_LAT, 2, accumulator register to NFU-3 result at o_to_nbout.

Ports:
- clk  in  1  main clock
- rst_n  in  1  synchronous active-low reset
- i_start  in  1  pulse; accepted only in IDLE
- i_num_in_tiles  in  CNT_W  input tiles per output tile; 0 treated as 1
- i_num_out_tiles  in  CNT_W  output tiles; 0 treated as 1
- i_psum_in  in  1  seed accumulator from NBout rather than zero
- i_psum_out  in  1  write NFU-2 partial sums rather than NFU-3 results
- i_load_coef  in  1  run the coefficient load phase before compute
- o_coef_addr  out  log2(NUM_SEG)  coefficient source index
- o_load_sigmoid_coef  out  1  to top_pipeline
- o_nbin_rd_en / o_nbin_addr  out  1 / ADDR_W  NBin read
- o_sb_rd_en / o_sb_addr  out  1 / ADDR_W  SB read
- o_nbout_rd_en / o_nbout_rd_addr  out  1 / ADDR_W  NBout partial-sum read
- o_load_nbout  out  1  to top_pipeline i_load_nbout
- o_psum_zero  out  1  forces i_nbout_to_nfu2 mux to zero
- o_nbout_nfu2_nfu3  out  1  to top_pipeline output select
- o_nbout_wr_en / o_nbout_wr_addr  out  1 / ADDR_W  NBout write of o_to_nbout
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse at layer end

Behaviour:
- Reset (rst_n low at a clk edge, any state): state=IDLE, all counters 0, every output 0. A layer in progress is abandoned with no write and no o_done.
- Config is latched on the i_start cycle. i_start in any state other than IDLE is ignored.
- States:
  - IDLE -> LOAD_COEF if i_load_coef, else ISSUE.
  - LOAD_COEF: NUM_SEG cycles with o_load_sigmoid_coef=1, o_coef_addr=0..NUM_SEG-1. Then -> ISSUE.
  - ISSUE: N=num_in_tiles consecutive cycles c..c+N-1.
    - o_nbin_rd_en=o_sb_rd_en=1.
    - nbin_addr = in index k.
    - sb_addr = running linear counter, out*N+k; it continues across output tiles and resets only at layer start.
  - DRAIN: wait until the result is valid, then assert the write for one cycle. Then -> ISSUE for the next output tile, or -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- Seed: o_load_nbout=1 for exactly one cycle L=c+ACC_LAT-1.
  - If i_psum_in=1: o_nbout_rd_en=1 with rd_addr=out tile index at cycle L-MEM_LAT, and o_psum_zero=0.
  - If i_psum_in=0: no read, and o_psum_zero=1 at L.
- Write: cycle W = c+ACC_LAT+N-1, plus NFU3_LAT if i_psum_out=0.
  - o_nbout_wr_en=1 and wr_addr=out tile index.
  - o_nbout_nfu2_nfu3 = i_psum_out, held for the whole layer.
- Next tile: the next output tile's ISSUE begins at W+1, with no overlap.
- Total cycles start->done: (NUM_SEG if coef) + num_out × (W-c+1) + 1.
- Widths: all counters saturate-free. Config guarantees num_out × num_in ≤ 2^ADDR_W; sb_addr wraps mod 2^ADDR_W.

Decomposition:
- Shared package nfu_pkg: state enum (IDLE, LOAD_COEF, ISSUE, DRAIN, DONE), BIT_WIDTH=16, Tn=16, latency constants.
- One sub-module nfu_tile_cnt: a reusable loadable up-counter with terminal-count flag. Used three times (in, out, latency).

Test Plan:
- Reset mid-ISSUE (rst_n low one cycle at cycle 3 of a 4×2 layer) -> all outputs 0 next cycle, no wr_en, no o_done, IDLE accepts new i_start.
- i_load_coef=1, start -> 16 cycles of o_load_sigmoid_coef with coef_addr 0..15, then first nbin_rd_en at the next cycle.
- num_in=4, num_out=2, psum_in=0, psum_out=0 -> sb_addr 0..3 then 4..7. load_nbout+psum_zero at c+2. wr_en at c+8, addr 0, then addr 1. o_done once.
- psum_in=1, psum_out=1, num_in=3, num_out=1 -> nbout_rd_en at c+1 addr 0, load_nbout at c+2 with psum_zero=0, wr_en at c+5 with o_nbout_nfu2_nfu3=1.
- num_in=0, num_out=0 -> behaves as 1×1: one read, one write at c+5 (psum_out=0), done.
- i_start pulsed while busy -> ignored; sb_addr/timing identical to the single-start run.
